booth_recoder: RTL and testbench
================================

Name: booth_recoder

Overview:
Radix-4 (modified) Booth recoder for the multiplier operand of the single-cycle 32x32 multiplier. Converts a 32-bit operand, signed or unsigned, into 17 Booth digits in {-2,-1,0,+1,+2}. Each digit is encoded as a one-hot magnitude (one/two) plus a sign flag, and drives the partial-product generator. Outputs are registered with one clock of latency.

Parameters:
None. Operand width is fixed at 32 bits and the digit count is fixed at 17.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset; synchronous and active-high
in_valid  input  1  qualifies op2 and s_or_us for capture this cycle
op2  input  32  operand to recode
s_or_us  input  1  1 = op2 is two's-complement signed; 0 = unsigned
out_valid  output  1  one/two/sign hold the recoding of a captured operand
one  output  17  bit i = 1 when digit i has magnitude 1
two  output  17  bit i = 1 when digit i has magnitude 2
sign  output  17  bit i = 1 when digit i is negative (nonzero)

Behaviour:
- Reset (rst=1 at a clk edge): one=0, two=0, sign=0, out_valid=0. Reset takes priority over in_valid.
- Operand extension to 34 bits b[33:0], with b[31:0]=op2:
  - unsigned: b[33]=b[32]=0
  - signed: b[33]=b[32]=op2[31]
  - b[-1]=0
- Digit i (i=0..16) is taken from the triplet (b[2i+1], b[2i], b[2i-1]):
  - 000 -> 0
  - 001 -> +1
  - 010 -> +1
  - 011 -> +2
  - 100 -> -2
  - 101 -> -1
  - 110 -> -1
  - 111 -> 0
- Per-digit encoding:
  - one[i] = b[2i] XOR b[2i-1]
  - two[i] = (b[2i+1] & ~b[2i] & ~b[2i-1]) | (~b[2i+1] & b[2i] & b[2i-1])
  - sign[i] = b[2i+1] & ~(b[2i] & b[2i-1])
  - For zero digits (000 and 111) all three bits are 0; there is no "negative zero".
- Invariants: one[i] and two[i] are never both 1; sign[i]=1 implies one[i]|two[i]=1.
- Recoded value: sum over i of d_i*4^i equals op2, read as unsigned or signed per s_or_us.
- Digit 16:
  - signed mode: triplet is always 000 or 111, so digit 16 is 0.
  - unsigned mode: digit 16 is +1 iff op2[31]=1, else 0.
- Timing:
  - Recoding is purely combinational from op2/s_or_us into the output registers.
  - At a rising edge with rst=0 and in_valid=1, one/two/sign load the recoding and out_valid<=1. Latency is 1 cycle.
  - At a rising edge with rst=0 and in_valid=0, one/two/sign hold their previous values and out_valid<=0.
- Back-to-back in_valid: a new result every cycle; no stalls and no internal state beyond the output registers.
- Reset asserted mid-stream clears the outputs at that edge. The operand presented with reset is discarded.

Test Plan:
1. Assert rst for 2 cycles with in_valid=1, op2=0xFFFFFFFF -> one=0, two=0, sign=0, out_valid=0. After rst drops, the next edge loads normally.
2. op2=0x00000000, s_or_us=0 and s_or_us=1 -> one=0x00000, two=0x00000, sign=0x00000, out_valid=1 one cycle later.
3. op2=0xFFFFFFFF:
   - unsigned -> one=0x10001, two=0x00000, sign=0x00001
   - signed -> one=0x00001, two=0x00000, sign=0x00001 (value -1)
4. op2=0x80000000:
   - unsigned -> one=0x10000, two=0x08000, sign=0x08000
   - signed -> one=0x00000, two=0x08000, sign=0x08000
5. op2=0x00000002 -> one=0x00002, two=0x00001, sign=0x00001 (both modes).
   op2=0x00000003 -> one=0x00003, two=0x00000, sign=0x00001 (both modes).
6. Random sweep: 1000 random op2 values in both modes, with in_valid toggled randomly. Check:
   - outputs one cycle later match a reference model
   - the sum of d_i*4^i reconstructs op2
   - the one/two exclusivity and sign invariants hold
   - outputs hold while in_valid=0

Source files
------------

// File: rtl/booth_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : booth_recoder
//  Description : Radix-4 (modified) Booth recoder for a 32-bit multiplier
//                operand. Produces 17 digits in {-2,-1,0,+1,+2}, each encoded
//                as one-hot magnitude (one/two) plus a sign flag, registered
//                with one clock of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_recoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] op2,
    input  logic        s_or_us,
    output logic        out_valid,
    output logic [16:0] one,
    output logic [16:0] two,
    output logic [16:0] sign
);

    localparam int c_DIGITS = 17;

    // Operand extended to 34 bits with an implicit zero below bit 0.
    // Index k of w_b_ext holds b[k-1], so b[-1] lives at w_b_ext[0].
    logic        w_ext_bit;
    logic [34:0] w_b_ext;

    logic [16:0] w_one;
    logic [16:0] w_two;
    logic [16:0] w_sign;

    logic        r_out_valid;
    logic [16:0] r_one;
    logic [16:0] r_two;
    logic [16:0] r_sign;

    // Sign-extend only in signed mode; unsigned operands get two zero bits
    // on top so the top digit can absorb op2[31] as +1.
    assign w_ext_bit = s_or_us & op2[31];
    assign w_b_ext   = {w_ext_bit, w_ext_bit, op2, 1'b0};

    // One overlapping triplet (b[2i+1], b[2i], b[2i-1]) per digit.
    generate
        for (genvar gi = 0; gi < c_DIGITS; gi++) begin : g_digit
            logic w_hi;
            logic w_mid;
            logic w_lo;

            assign w_hi  = w_b_ext[2*gi+2];
            assign w_mid = w_b_ext[2*gi+1];
            assign w_lo  = w_b_ext[2*gi];

            // Magnitude 1 when exactly one of the two low bits is set.
            assign w_one[gi]  = w_mid ^ w_lo;
            // Magnitude 2 for triplets 100 (-2) and 011 (+2).
            assign w_two[gi]  = (w_hi & ~w_mid & ~w_lo) | (~w_hi & w_mid & w_lo);
            // Negative only for nonzero digits: 111 is zero, not negative zero.
            assign w_sign[gi] = w_hi & ~(w_mid & w_lo);
        end
    endgenerate

    // Output registers: load on a valid operand, hold otherwise; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_one       <= '0;
            r_two       <= '0;
            r_sign      <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_one  <= w_one;
                r_two  <= w_two;
                r_sign <= w_sign;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign one       = r_one;
    assign two       = r_two;
    assign sign      = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_booth_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_recoder
//  Description : Self-checking bench for booth_recoder: directed vector table,
//                reset sequences and a random sweep with a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_recoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] op2;
    logic        s_or_us;
    logic        out_valid;
    logic [16:0] one;
    logic [16:0] two;
    logic [16:0] sign;

    booth_recoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op2       (op2),
        .s_or_us   (s_or_us),
        .out_valid (out_valid),
        .one       (one),
        .two       (two),
        .sign      (sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic        s;
        logic [16:0] one;
        logic [16:0] two;
        logic [16:0] sign;
    } vec_t;

    vec_t        sb_q[$];
    vec_t        last_exp;
    bit          have_last;
    int          n_checks;
    int          n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: digit table lookup per triplet, then pack to one/two/sign.
    function automatic vec_t ref_model(input logic [31:0] op, input logic s);
        vec_t        r;
        logic [34:0] bb;
        logic [2:0]  t;
        int          d;
        bb = {s & op[31], s & op[31], op, 1'b0};
        r.op = op; r.s = s; r.one = '0; r.two = '0; r.sign = '0;
        for (int i = 0; i < 17; i++) begin
            t = bb[2*i+2 -: 3];
            case (t)
                3'b000: d = 0;
                3'b001: d = 1;
                3'b010: d = 1;
                3'b011: d = 2;
                3'b100: d = -2;
                3'b101: d = -1;
                3'b110: d = -1;
                default: d = 0;
            endcase
            r.one[i]  = (d == 1) || (d == -1);
            r.two[i]  = (d == 2) || (d == -2);
            r.sign[i] = (d < 0);
        end
        return r;
    endfunction

    // Value represented by a one/two/sign digit vector.
    function automatic longint decode(input logic [16:0] o, input logic [16:0] w, input logic [16:0] sg);
        longint v;
        longint d;
        v = 0;
        for (int i = 0; i < 17; i++) begin
            d = o[i] ? 1 : (w[i] ? 2 : 0);
            if (sg[i]) d = -d;
            v = v + d * (longint'(1) <<< (2*i));
        end
        return v;
    endfunction

    // Drive one cycle of stimulus and check what the DUT shows after the edge.
    task automatic cycle(input bit v, input logic [31:0] op, input bit s, input bit rs, input bit deep);
        vec_t   e;
        longint want;
        rst = rs; in_valid = v; op2 = op; s_or_us = s;
        if (!rs && v) sb_q.push_back(ref_model(op, s));
        @(posedge clk);
        #1;
        if (rs) begin
            sb_q.delete();
            have_last = 0;
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_one",   64'(one),  64'd0);
            chk("rst_two",   64'(two),  64'd0);
            chk("rst_sign",  64'(sign), 64'd0);
        end else if (v) begin
            chk("out_valid", 64'(out_valid), 64'd1);
            if (sb_q.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("one",  64'(one),  64'(e.one));
                chk("two",  64'(two),  64'(e.two));
                chk("sign", 64'(sign), 64'(e.sign));
                if (deep) begin
                    want = e.s ? longint'($signed(e.op)) : longint'({32'd0, e.op});
                    chk("recon", 64'(decode(one, two, sign)), 64'(want));
                    chk("excl",  64'(one & two), 64'd0);
                    chk("signinv", 64'(sign & ~(one | two)), 64'd0);
                end
                last_exp  = e;
                have_last = 1;
            end
        end else begin
            chk("idle_valid", 64'(out_valid), 64'd0);
            if (have_last) begin
                chk("hold_one",  64'(one),  64'(last_exp.one));
                chk("hold_two",  64'(two),  64'(last_exp.two));
                chk("hold_sign", 64'(sign), 64'(last_exp.sign));
            end
        end
    endtask

    vec_t vecs[10];

    initial begin
        n_checks = 0; n_pass = 0; have_last = 0;
        rst = 1'b1; in_valid = 1'b1; op2 = 32'hFFFF_FFFF; s_or_us = 1'b0;

        // Directed vectors with hand-derived expectations.
        vecs[0] = '{32'h0000_0000, 1'b0, 17'h00000, 17'h00000, 17'h00000};
        vecs[1] = '{32'h0000_0000, 1'b1, 17'h00000, 17'h00000, 17'h00000};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 17'h10001, 17'h00000, 17'h00001};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 17'h00001, 17'h00000, 17'h00001};
        vecs[4] = '{32'h8000_0000, 1'b0, 17'h10000, 17'h08000, 17'h08000};
        vecs[5] = '{32'h8000_0000, 1'b1, 17'h00000, 17'h08000, 17'h08000};
        vecs[6] = '{32'h0000_0002, 1'b0, 17'h00002, 17'h00001, 17'h00001};
        vecs[7] = '{32'h0000_0002, 1'b1, 17'h00002, 17'h00001, 17'h00001};
        vecs[8] = '{32'h0000_0003, 1'b0, 17'h00003, 17'h00000, 17'h00001};
        vecs[9] = '{32'h0000_0003, 1'b1, 17'h00003, 17'h00000, 17'h00001};

        // Reset held two cycles with a valid operand present.
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        // First edge after reset loads normally.
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

        // Directed table: queue the expectation, compare against the DUT.
        for (int i = 0; i < 10; i++) begin
            rst = 1'b0; in_valid = 1'b1; op2 = vecs[i].op; s_or_us = vecs[i].s;
            sb_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            chk("tbl_valid", 64'(out_valid), 64'd1);
            begin
                vec_t e;
                e = sb_q.pop_front();
                chk($sformatf("tbl%0d_one", i),  64'(one),  64'(e.one));
                chk($sformatf("tbl%0d_two", i),  64'(two),  64'(e.two));
                chk($sformatf("tbl%0d_sign", i), 64'(sign), 64'(e.sign));
                last_exp = e; have_last = 1;
            end
        end

        // Hold across idle cycles, then a mid-stream reset with operand.
        cycle(1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h5A5A_5A5A, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);

        // Random sweep: each value in both modes, random idle gaps.
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] r;
            r = $urandom;
            cycle(1'b1, r, 1'b0, 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) cycle(1'b0, $urandom, 1'($urandom), 1'b0, 1'b0);
            cycle(1'b1, r, 1'b1, 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) cycle(1'b0, $urandom, 1'($urandom), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
